// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-core memory port arbiter.
//   state_t : arbiter FSM states
//   op_t    : access type latched at grant time
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick.
// Ports:
//   eligible    in  2  per-core eligibility
//   last_grant  in  1  core granted most recently
//   grant_valid out 1  at least one core eligible
//   grant_idx   out 1  chosen core
module rr_arbiter2 (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |eligible;
    grant_idx   = 1'b0;
    // On a tie the core that did not win last time goes first.
    if (eligible == 2'b11) grant_idx = ~last_grant;
    else                   grant_idx = eligible[1];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises the two cores' load/store requests onto the single memory data
// port with round-robin priority, one access in flight at a time.
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   req_rd/req_wr [1:0]      per-core level requests, held until completion
//   req_adrs, req_wdata      per-core address / store data (core i in slice i)
//   rd_valid/wr_valid [1:0]  one-cycle completion pulse to the served core
//   rd_data                  per-core registered load data (core i in slice i)
//   mem_r_en/mem_w_en        one-cycle memory enables
//   mem_adrs, mem_wdata      memory address / write data
//   mem_r_valid/mem_w_valid  memory completion, mem_rdata with mem_r_valid
//   timeout_err              one-cycle pulse when an access is abandoned
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            req_rd,
  input  logic [1:0]            req_wr,
  input  logic [2*ADDR_W-1:0]   req_adrs,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            rd_valid,
  output logic [1:0]            wr_valid,
  output logic [2*DATA_W-1:0]   rd_data,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  output logic [ADDR_W-1:0]     mem_adrs,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_r_valid,
  input  logic                  mem_w_valid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              state, state_nxt;
  op_t                 op;
  logic                winner;
  logic                last_grant;
  logic [1:0]          cool;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   lat_adrs;
  logic [DATA_W-1:0]   lat_wdata;
  logic [1:0]          eligible;
  logic                grant_valid;
  logic                grant_idx;
  logic                mem_done;
  logic                timed_out;
  logic [1:0]          winner_mask;

  // A core that was just served is masked for one cycle while its request
  // drops, so it cannot be granted again on a stale level.
  assign eligible    = (req_rd | req_wr) & ~cool;
  assign winner_mask = {winner, ~winner};

  rr_arbiter2 u_rr (
    .eligible    (eligible),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_nxt = state;
    mem_done  = 1'b0;
    timed_out = 1'b0;
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    mem_adrs  = '0;
    mem_wdata = '0;
    rd_valid  = 2'b00;
    wr_valid  = 2'b00;
    case (state)
      IDLE: if (grant_valid) state_nxt = ISSUE;
      ISSUE: begin
        mem_adrs  = lat_adrs;
        mem_wdata = lat_wdata;
        mem_r_en  = (op == OP_RD);
        mem_w_en  = (op == OP_WR);
        state_nxt = WAIT;
      end
      WAIT: begin
        mem_adrs  = lat_adrs;
        mem_wdata = lat_wdata;
        // Only the completion matching the issued op counts.
        mem_done  = (op == OP_WR) ? mem_w_valid : mem_r_valid;
        if (mem_done) begin
          state_nxt = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          timed_out = 1'b1;
          state_nxt = IDLE;
        end
      end
      RESP: begin
        if (op == OP_RD) rd_valid = winner_mask;
        else             wr_valid = winner_mask;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      op          <= OP_RD;
      winner      <= 1'b0;
      last_grant  <= 1'b1;
      cool        <= 2'b00;
      cnt         <= '0;
      timeout_err <= 1'b0;
      rd_data     <= '0;
    end else begin
      state       <= state_nxt;
      cool        <= 2'b00;
      timeout_err <= timed_out;
      case (state)
        IDLE: if (grant_valid) begin
          winner     <= grant_idx;
          last_grant <= grant_idx;
          // A core asking for both gets its store first.
          op         <= req_wr[grant_idx] ? OP_WR : OP_RD;
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_done && op == OP_RD) begin
            if (winner) rd_data[2*DATA_W-1:DATA_W] <= mem_rdata;
            else        rd_data[DATA_W-1:0]        <= mem_rdata;
          end
        end
        RESP: cool <= winner_mask;
        default: ;
      endcase
    end
  end

  // Address/data latch; only driven onto the port during ISSUE/WAIT
  always_ff @(posedge clk) begin
    if (state == IDLE && grant_valid) begin
      lat_adrs  <= grant_idx ? req_adrs[2*ADDR_W-1:ADDR_W]   : req_adrs[ADDR_W-1:0];
      lat_wdata <= grant_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency memory responder.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  logic                clk;
  logic                resetn;
  logic [1:0]          req_rd, req_wr;
  logic [2*ADDR_W-1:0] req_adrs;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rd_valid, wr_valid;
  logic [2*DATA_W-1:0] rd_data;
  logic                mem_r_en, mem_w_en;
  logic [ADDR_W-1:0]   mem_adrs;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_r_valid, mem_w_valid;
  logic [DATA_W-1:0]   mem_rdata;
  logic                timeout_err;

  int vectors = 0;
  int miscompares = 0;
  int overlap = 0;
  logic mute = 1'b0;
  logic [DATA_W-1:0] rd_value = '0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)) dut (
    .clk(clk), .resetn(resetn),
    .req_rd(req_rd), .req_wr(req_wr), .req_adrs(req_adrs), .req_wdata(req_wdata),
    .rd_valid(rd_valid), .wr_valid(wr_valid), .rd_data(rd_data),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_adrs(mem_adrs), .mem_wdata(mem_wdata),
    .mem_r_valid(mem_r_valid), .mem_w_valid(mem_w_valid), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: answers an enable seen in one cycle during the next cycle.
  initial begin : responder
    logic pend_r, pend_w;
    pend_r = 1'b0;
    pend_w = 1'b0;
    mem_r_valid = 1'b0;
    mem_w_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_r_valid = pend_r;
      mem_w_valid = pend_w;
      mem_rdata   = pend_r ? rd_value : '0;
      pend_r = mem_r_en && !mute;
      pend_w = mem_w_en && !mute;
      if (mem_r_en && mem_w_en) overlap++;
      if ($countones(rd_valid | wr_valid) > 1) overlap++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic order [8];
    int n, c0, c1;
    resetn = 1'b0;
    req_rd = 2'b00;
    req_wr = 2'b00;
    req_adrs = '0;
    req_wdata = '0;
    #12;
    chk("rst_outputs", {mem_r_en, mem_w_en, rd_valid, wr_valid, timeout_err}, 0);
    chk("rst_mem_adrs", mem_adrs, 0);
    chk("rst_rd_data", rd_data, 0);
    tick();
    resetn = 1'b1;

    // Single read by core 0
    req_rd = 2'b01;
    req_adrs[ADDR_W-1:0] = 11'h010;
    rd_value = 32'hDEADBEEF;
    tick();
    chk("t1_r_en", {mem_r_en, mem_w_en}, 2'b10);
    chk("t1_adrs", mem_adrs, 11'h010);
    tick();
    chk("t1_no_early_valid", rd_valid, 2'b00);
    tick();
    chk("t1_rd_valid", rd_valid, 2'b01);
    chk("t1_rd_data", rd_data[31:0], 32'hDEADBEEF);
    tick();
    chk("t1_pulse_one_cycle", rd_valid, 2'b00);
    req_rd = 2'b00;
    tick();
    chk("t1_cooldown_blocks", mem_r_en, 1'b0);
    tick();

    // Simultaneous store (core 0) and load (core 1) after a fresh reset
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    req_wr = 2'b01;
    req_rd = 2'b10;
    req_adrs = {11'h006, 11'h005};
    req_wdata = {32'h0, 32'h11111111};
    rd_value = 32'hCAFEF00D;
    tick();
    chk("t2_w_en", {mem_r_en, mem_w_en}, 2'b01);
    chk("t2_w_adrs", mem_adrs, 11'h005);
    chk("t2_wdata", mem_wdata, 32'h11111111);
    tick();
    tick();
    chk("t2_wr_valid", {rd_valid, wr_valid}, 4'b0001);
    tick();
    req_wr = 2'b00;
    tick();
    chk("t2_r_en", {mem_r_en, mem_w_en}, 2'b10);
    chk("t2_r_adrs", mem_adrs, 11'h006);
    tick();
    tick();
    chk("t2_rd_valid", {rd_valid, wr_valid}, 4'b1000);
    chk("t2_rd_data", rd_data, {32'hCAFEF00D, 32'h0});
    tick();
    req_rd = 2'b00;
    tick();
    tick();

    // Continuous contention, 8 grants
    req_rd = 2'b11;
    req_adrs = {11'h101, 11'h100};
    rd_value = 32'h00003333;
    n = 0; c0 = 0; c1 = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      tick();
      if (rd_valid != 2'b00) begin
        order[n] = rd_valid[1];
        if (rd_valid[0]) c0++;
        if (rd_valid[1]) c1++;
        n++;
        if (n == 8) req_rd = 2'b00;
      end
    end
    chk("t3_grants", n, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("t3_order%0d", k), order[k], k % 2);
    chk("t3_core0_pulses", c0, 4);
    chk("t3_core1_pulses", c1, 4);
    tick();
    tick();

    // Core 1 holds store and load together
    req_wr = 2'b10;
    req_rd = 2'b10;
    req_adrs = {11'h020, 11'h000};
    req_wdata = {32'h22220020, 32'h0};
    rd_value = 32'h0BAD0020;
    tick();
    chk("t4_w_first", {mem_r_en, mem_w_en}, 2'b01);
    chk("t4_w_adrs", mem_adrs, 11'h020);
    chk("t4_w_data", mem_wdata, 32'h22220020);
    tick();
    tick();
    chk("t4_wr_valid", {rd_valid, wr_valid}, 4'b0010);
    tick();
    req_wr = 2'b00;
    tick();
    chk("t4_cooldown", {mem_r_en, mem_w_en}, 2'b00);
    tick();
    chk("t4_r_second", {mem_r_en, mem_w_en}, 2'b10);
    tick();
    tick();
    chk("t4_rd_valid", {rd_valid, wr_valid}, 4'b1000);
    chk("t4_rd_data", rd_data[63:32], 32'h0BAD0020);
    tick();
    req_rd = 2'b00;
    tick();
    tick();

    // Timeout on a core 0 read
    mute = 1'b1;
    req_rd = 2'b01;
    req_adrs = {11'h000, 11'h033};
    tick();
    chk("t5_r_en", mem_r_en, 1'b1);
    n = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (rd_valid != 2'b00 || timeout_err) n++;
    end
    chk("t5_quiet_wait", n, 0);
    tick();
    chk("t5_timeout_err", timeout_err, 1'b1);
    chk("t5_no_rd_valid", rd_valid, 2'b00);
    mute = 1'b0;
    rd_value = 32'h77770033;
    tick();
    chk("t5_reissue", {mem_r_en, timeout_err}, 2'b10);
    chk("t5_reissue_adrs", mem_adrs, 11'h033);
    tick();
    tick();
    chk("t5_rd_valid", rd_valid, 2'b01);
    chk("t5_rd_data", rd_data[31:0], 32'h77770033);
    tick();
    req_rd = 2'b00;
    tick();
    tick();

    // Reset while core 1 waits
    mute = 1'b1;
    req_rd = 2'b10;
    req_adrs = {11'h044, 11'h055};
    tick();
    tick();
    req_rd = 2'b11;
    tick();
    chk("t6_wait_adrs", mem_adrs, 11'h044);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_async_adrs", mem_adrs, 0);
    chk("t6_async_ctrl", {mem_r_en, mem_w_en, rd_valid, wr_valid, timeout_err}, 0);
    chk("t6_async_rd_data", rd_data, 0);
    mute = 1'b0;
    rd_value = 32'h55550055;
    resetn = 1'b1;
    tick();
    chk("t6_core0_first", mem_r_en, 1'b1);
    chk("t6_core0_adrs", mem_adrs, 11'h055);
    tick();
    tick();
    chk("t6_rd_valid", rd_valid, 2'b01);
    chk("t6_rd_data", rd_data, {32'h0, 32'h55550055});
    req_rd = 2'b00;
    tick();
    tick();

    chk("no_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
